// File: rtl/signed_seq_divider_if.sv
// signed_seq_divider_if: start/busy/done handshake and operand/result bus for the signed divider
interface signed_seq_divider_if #(parameter int WIDTH = 8);
  logic                 start;
  logic [2*WIDTH-1:0]   dividend;
  logic [WIDTH-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     quotient;
  logic [WIDTH-1:0]     remainder;
  logic                 overflow;
  logic                 div_by_zero;
  modport master (output start, dividend, divisor, input busy, done, quotient, remainder, overflow, div_by_zero);
  modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, overflow, div_by_zero);
endinterface

// File: rtl/signed_seq_divider.sv
// signed_seq_divider: 2W/W signed restoring divider, one quotient bit per clock, sign fix-up and overflow in a final cycle
module signed_seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  signed_seq_divider_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;
  localparam int CW = $clog2(2*WIDTH);
  localparam logic [2*WIDTH-1:0] QPOS = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] QNEG = QPOS + 1'b1;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] dvd, qmag, dvd_abs;
  logic [WIDTH-1:0] dvs, dvs_abs, rem, rem_sub, qval, rval;
  logic [WIDTH:0] rem_sh;
  logic sd, sv, dz, ge, qneg, ovf, last;
  always_comb begin
    dvd_abs = bus.dividend[2*WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_abs = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    rem_sh = {rem, dvd[2*WIDTH-1]};
    ge = rem_sh >= {1'b0, dvs};
    // the restored remainder is always below the divisor, so W-bit wraparound is exact
    rem_sub = rem_sh[WIDTH-1:0] - dvs;
    last = cnt == CW'(2*WIDTH-1);
    qneg = sd ^ sv;
    ovf = !dz && (qneg ? qmag > QNEG : qmag > QPOS);
    qval = dz ? '0 :
           ovf ? (qneg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) :
           qneg ? -qmag[WIDTH-1:0] : qmag[WIDTH-1:0];
    rval = dz ? '0 : sd ? -rem : rem;
    state_nx = state == IDLE ? (bus.start ? DIV : IDLE) :
               state == DIV  ? (last ? FIX : DIV) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      qmag <= '0;
      sd <= 1'b0;
      sv <= 1'b0;
      dz <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
      bus.overflow <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.busy <= state_nx != IDLE;
      bus.done <= state == FIX;
      if (state == IDLE && bus.start) begin
        dvd <= dvd_abs;
        dvs <= dvs_abs;
        sd <= bus.dividend[2*WIDTH-1];
        sv <= bus.divisor[WIDTH-1];
        dz <= bus.divisor == '0;
        cnt <= '0;
        rem <= '0;
        qmag <= '0;
      end
      if (state == DIV) begin
        rem <= ge ? rem_sub : rem_sh[WIDTH-1:0];
        qmag <= {qmag[2*WIDTH-2:0], ge};
        dvd <= {dvd[2*WIDTH-2:0], 1'b0};
        cnt <= cnt + 1'b1;
      end
      if (state == FIX) begin
        bus.quotient <= qval;
        bus.remainder <= rval;
        bus.overflow <= ovf;
        bus.div_by_zero <= dz;
      end
    end
endmodule
